// File: rtl/msi_directory_controller.sv
// MSI coherence engine: takes one access descriptor and works out the next cache 1, directory
// and cache 2 states, the bus message and the write-back flag over a fixed five-cycle sequence.
module msi_directory_controller #(
  parameter logic [2:0] ST_I = 3'b001,
  parameter logic [2:0] ST_S = 3'b010,
  parameter logic [2:0] ST_M = 3'b011
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] WriteRead,
  input  logic [1:0] HitMiss,
  input  logic [2:0] stateCache,
  input  logic [2:0] stateDiretorio,
  input  logic [2:0] stateCache2,
  output logic [2:0] nextCache,
  output logic [2:0] nextDiretorio,
  output logic [2:0] nextCache2,
  output logic [1:0] Message,
  output logic       WriteBack,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [7:0] TxCount
);

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_RM   = 2'b01;
  localparam logic [1:0] MSG_WM   = 2'b10;
  localparam logic [1:0] MSG_INV  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOCAL, DIR, REMOTE, DONE} state_t;

  state_t state;
  logic   capWrite;
  logic   capHit;

  function automatic logic isLegal(input logic [2:0] s);
    return (s == ST_I) || (s == ST_S) || (s == ST_M);
  endfunction

  function automatic logic [2:0] normState(input logic [2:0] s);
    return isLegal(s) ? s : ST_I;
  endfunction

  // The next* registers double as the captured copies of the incoming states; each phase
  // overwrites only its own field, so untouched states simply read back unchanged.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      capWrite      <= 1'b0;
      capHit        <= 1'b0;
      nextCache     <= ST_I;
      nextDiretorio <= ST_I;
      nextCache2    <= ST_I;
      Message       <= MSG_NONE;
      WriteBack     <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Error         <= 1'b0;
      TxCount       <= 8'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state         <= LOCAL;
            Busy          <= 1'b1;
            capWrite      <= (WriteRead == 2'b01);
            capHit        <= (HitMiss == 2'b01);
            nextCache     <= normState(stateCache);
            nextDiretorio <= normState(stateDiretorio);
            nextCache2    <= normState(stateCache2);
            Message       <= MSG_NONE;
            WriteBack     <= 1'b0;
            Error         <= !isLegal(stateCache) || !isLegal(stateDiretorio) ||
                             !isLegal(stateCache2) || WriteRead[1] || HitMiss[1];
          end
        end
        LOCAL: begin
          state <= DIR;
          if (nextCache == ST_S) begin
            if (capWrite) begin
              nextCache <= ST_M;
              Message   <= capHit ? MSG_INV : MSG_WM;
            end else if (!capHit) begin
              Message <= MSG_RM;
            end
          end else if (nextCache == ST_M) begin
            if (!capHit) begin
              WriteBack <= 1'b1;
              if (capWrite) begin
                Message <= MSG_WM;
              end else begin
                nextCache <= ST_S;
                Message   <= MSG_RM;
              end
            end
          end else begin
            // An I line always misses, whatever HitMiss claimed.
            nextCache <= capWrite ? ST_M : ST_S;
            Message   <= capWrite ? MSG_WM : MSG_RM;
          end
        end
        DIR: begin
          state <= REMOTE;
          case (Message)
            MSG_RM:          nextDiretorio <= ST_S;
            MSG_WM, MSG_INV: nextDiretorio <= ST_M;
            default:         nextDiretorio <= nextDiretorio;
          endcase
        end
        REMOTE: begin
          state   <= DONE;
          Done    <= 1'b1;
          TxCount <= TxCount + 8'd1;
          if (nextCache2 == ST_M) begin
            if (Message == MSG_RM) begin
              nextCache2 <= ST_S;
              WriteBack  <= 1'b1;
            end else if (Message == MSG_WM) begin
              nextCache2 <= ST_I;
              WriteBack  <= 1'b1;
            end
          end else if (nextCache2 == ST_S && (Message == MSG_WM || Message == MSG_INV)) begin
            nextCache2 <= ST_I;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
